hlsi_stream_fifo: RTL and testbench
===================================

// Module: hlsi_stream_fifo
// PURPOSE
//  Elastic FIFO stage between two HLS kernels on the data/ready/enable stream interface.
//  Upstream producer drives dataL/readyL; this block answers with enableL.
//  Downstream consumer sees dataR/readyR and answers with enableR.
//  Decouples kernel stalls; drops into any inter-kernel link (e.g. between knl0 and knl1) without protocol change.
// PARAMETERS
//  WIDTH   32  payload width in bits
//  DEPTH   4   number of entries; power of two, >= 2
//  LW      $clog2(DEPTH)+1 (localparam)  width of f_level
// PORTS
//  sys_clk    in   1      clock; all state changes on rising edge
//  sys_rst_n  in   1      asynchronous reset, active low
//  f_dataL    in   WIDTH  upstream payload
//  f_readyL   in   1      upstream has valid payload this cycle
//  f_enableL  out  1      FIFO accepts upstream payload this cycle
//  f_dataR    out  WIDTH  head-of-FIFO payload
//  f_readyR   out  1      FIFO holds valid payload for downstream
//  f_enableR  in   1      downstream accepts f_dataR this cycle
//  f_level    out  LW     current occupancy, 0..DEPTH
// BEHAVIOUR
//  Clock and reset
//  - One clock: sys_clk; reset is asynchronous and active-low.
//  Reset
//  - sys_rst_n=0 clears rd/wr pointers and f_level to 0 immediately.
//  - Reset outputs: f_enableL=1, f_readyR=0, f_dataR=0, f_level=0.
//  - Storage array is not reset.
//  - Mid-operation reset discards all entries; no partial transfer is completed.
//  Transfers
//  - push = f_readyL & f_enableL; pop = f_readyR & f_enableR.
//  - Each is one word per cycle.
//  Handshake outputs
//  - f_enableL = (level != DEPTH). It depends only on state, never on f_readyL (no comb path).
//  - f_readyR = (level != 0). It depends only on state, never on f_enableR (no comb path).
//  - f_dataR = mem[rd_ptr] (first-word-fall-through).
//  - f_dataR is stable while f_readyR=1 and no pop occurs.
//  Latency and throughput
//  - A word pushed at edge N appears on f_dataR with f_readyR=1 after edge N.
//  - Minimum latency is 1 cycle; there is no combinational bypass.
//  - Sustained throughput is 1 word/cycle once level is between 1 and DEPTH-1.
//  Pointers
//  - rd_ptr/wr_ptr are LW bits wide; the low bits address storage and the MSB is the wrap flag.
//  - Full when the low bits are equal and the MSBs differ; empty when the pointers are identical.
//  - Wrap-around from DEPTH-1 to 0 is silent.
//  Level
//  - push only: +1.  pop only: -1.  push & pop together: unchanged.
//  Boundary conditions
//  - Full: f_enableL=0, so no push even if a pop occurs that cycle.
//    The freed slot becomes available at the next cycle.
//  - Empty: f_readyR=0, so no pop. A simultaneous push lands and is visible next cycle.
//  - Full with pop and f_readyL=1: only the pop happens; level goes DEPTH -> DEPTH-1.
//  Ordering and hold
//  - Strict FIFO order; no word is dropped or duplicated.
//  - Words are accepted only on the push condition.
//  - f_dataL/f_readyL may change freely while f_enableL=0.
// TESTING
//  1. Reset: sys_rst_n=0 then release.
//     -> f_enableL=1, f_readyR=0, f_level=0, f_dataR=0.
//  2. Single word: push 0xDEADBEEF with f_enableR=0.
//     -> next cycle f_readyR=1, f_dataR=0xDEADBEEF, f_level=1.
//     Set f_enableR=1 -> following cycle f_readyR=0, f_level=0.
//  3. Fill (DEPTH=4): push 0x1..0x4 with f_enableR=0.
//     -> f_level=4, f_enableL=0; a 5th word 0x5 held on f_readyL is not accepted.
//     Pop once -> level=3; 0x5 accepted the following cycle.
//     Drain order is 0x1,0x2,0x3,0x4,0x5.
//  4. Streaming: f_readyL=1 and f_enableR=1 every cycle, 20 words 0..19.
//     -> output 0..19 in order at 1 word/cycle after 1-cycle latency.
//     f_level stays at 1; pointers wrap 5 times.
//  5. Random stalls: 1000 words, 50% random f_readyL and f_enableR.
//     -> scoreboard exact order match; f_level always within 0..4.
//     f_enableL never 1 while full; f_readyR never 1 while empty.
//  6. Mid-run reset: at level=3 assert sys_rst_n=0 asynchronously (between edges).
//     -> outputs go to reset values within the same cycle.
//     After release, the first popped word is the first word pushed after reset.

Source files
------------

// File: rtl/hlsi_stream_fifo.sv
// -----------------------------------------------------------------------------
// hlsi_stream_fifo
//
// Elastic FIFO stage between two HLS kernels using the data/ready/enable
// stream interface. It isolates the producer from consumer stalls and the
// consumer from producer stalls, so it can be dropped into any inter-kernel
// link with no protocol change.
//
// Handshake semantics (both sides):
//   - A word moves across a side on a rising edge where that side's
//     "ready" (payload valid) and "enable" (accept) are both 1.
//   - push = f_readyL & f_enableL ; pop = f_readyR & f_enableR.
//   - f_enableL and f_readyR are functions of registered state only, so
//     there is no combinational path from f_readyL or f_enableR.
//   - The producer may change f_dataL/f_readyL freely while f_enableL = 0.
//
// Ports:
//   sys_clk    in   1      clock, all state changes on the rising edge
//   sys_rst_n  in   1      asynchronous reset, active low
//   f_dataL    in   WIDTH  upstream payload
//   f_readyL   in   1      upstream has a valid payload this cycle
//   f_enableL  out  1      FIFO accepts the upstream payload this cycle
//   f_dataR    out  WIDTH  head-of-FIFO payload (first-word-fall-through)
//   f_readyR   out  1      FIFO holds a valid payload for downstream
//   f_enableR  in   1      downstream accepts f_dataR this cycle
//   f_level    out  LW     current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module hlsi_stream_fifo #(
   parameter int  WIDTH = 32,
   parameter int  DEPTH = 4,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [WIDTH-1:0] f_dataL,
   input  logic             f_readyL,
   output logic             f_enableL,
   output logic [WIDTH-1:0] f_dataR,
   output logic             f_readyR,
   input  logic             f_enableR,
   output logic [LW-1:0]    f_level
);

   localparam int AW = LW - 1;

   // Pointers carry one extra bit above the storage address: it toggles on
   // every wrap so that full and empty can be told apart.
   logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[LW-1]   != rd_ptr_q[LW-1]);

   assign f_enableL = ~full;
   assign f_readyR  = ~empty;

   assign push = f_readyL & f_enableL;
   assign pop  = f_readyR & f_enableR;

   // With a power-of-two depth the modular pointer difference is exactly
   // the occupancy, including the full case (difference == DEPTH).
   assign f_level = wr_ptr_q - rd_ptr_q;

   // Storage is unreset, so the head is masked while empty; this gives a
   // clean zero on f_dataR after reset and whenever nothing is held.
   assign f_dataR = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= f_dataL;
   end

endmodule

// File: tb/tb_hlsi_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_hlsi_stream_fifo
//
// Bench for hlsi_stream_fifo. Inputs change on the falling edge; outputs are
// checked 2 ns after each rising edge against a queue-based model of the FIFO.
// Directed sequences add literal expectations that pin the model itself.
// -----------------------------------------------------------------------------
module tb_hlsi_stream_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             sys_clk;
   logic             sys_rst_n;
   logic [WIDTH-1:0] f_dataL;
   logic             f_readyL;
   logic             f_enableL;
   logic [WIDTH-1:0] f_dataR;
   logic             f_readyR;
   logic             f_enableR;
   logic [LW-1:0]    f_level;

   int n_checks = 0;
   int n_fail   = 0;
   int push_cnt = 0;

   // Expected contents, head at index 0.
   logic [WIDTH-1:0] exp_q[$];

   hlsi_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .f_dataL   (f_dataL),
      .f_readyL  (f_readyL),
      .f_enableL (f_enableL),
      .f_dataR   (f_dataR),
      .f_readyR  (f_readyR),
      .f_enableR (f_enableR),
      .f_level   (f_level)
   );

   // ---------------- clock ----------------
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ---------------- checker helper ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A word is accepted when offered and the queue has room; a word leaves
   // when the consumer accepts and the queue is not empty. Reset empties it.
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         exp_q.delete();
      end else begin
         bit do_push;
         bit do_pop;
         do_push = (f_readyL === 1'b1) && (exp_q.size() < DEPTH);
         do_pop  = (f_enableR === 1'b1) && (exp_q.size() > 0);
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) begin
            exp_q.push_back(f_dataL);
            push_cnt++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always begin
      @(posedge sys_clk);
      #2;
      chk("cyc_enableL", {63'd0, f_enableL}, {63'd0, exp_q.size() != DEPTH});
      chk("cyc_readyR",  {63'd0, f_readyR},  {63'd0, exp_q.size() != 0});
      chk("cyc_level",   {{(64-LW){1'b0}}, f_level}, 64'(exp_q.size()));
      chk("cyc_dataR",   {32'd0, f_dataR}, (exp_q.size() != 0) ? {32'd0, exp_q[0]} : 64'd0);
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic rl, input logic [WIDTH-1:0] d, input logic er);
      @(negedge sys_clk);
      f_readyL  = rl;
      f_dataL   = d;
      f_enableR = er;
   endtask

   task automatic settle();
      @(posedge sys_clk);
      #2;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      sys_rst_n = 1'b0;
      f_readyL  = 1'b0;
      f_dataL   = '0;
      f_enableR = 1'b0;

      // 1. reset values
      repeat (2) @(negedge sys_clk);
      chk("rst_enableL", {63'd0, f_enableL}, 64'd1);
      chk("rst_readyR",  {63'd0, f_readyR},  64'd0);
      chk("rst_level",   {{(64-LW){1'b0}}, f_level}, 64'd0);
      chk("rst_dataR",   {32'd0, f_dataR}, 64'd0);
      sys_rst_n = 1'b1;

      // 2. single word
      drive(1'b1, 32'hDEADBEEF, 1'b0);
      settle();
      chk("single_readyR", {63'd0, f_readyR}, 64'd1);
      chk("single_dataR",  {32'd0, f_dataR}, 64'hDEADBEEF);
      chk("single_level",  {{(64-LW){1'b0}}, f_level}, 64'd1);
      drive(1'b0, '0, 1'b1);
      settle();
      chk("single_pop_readyR", {63'd0, f_readyR}, 64'd0);
      chk("single_pop_level",  {{(64-LW){1'b0}}, f_level}, 64'd0);

      // 3. fill, blocked word, pop, then drain order
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 32'(i), 1'b0);
         settle();
      end
      chk("fill_level",   {{(64-LW){1'b0}}, f_level}, 64'd4);
      chk("fill_enableL", {63'd0, f_enableL}, 64'd0);
      chk("fill_head",    {32'd0, f_dataR}, 64'd1);
      drive(1'b1, 32'h5, 1'b0);
      settle();
      chk("full_hold_level", {{(64-LW){1'b0}}, f_level}, 64'd4);
      drive(1'b1, 32'h5, 1'b1);
      settle();
      chk("full_pop_level", {{(64-LW){1'b0}}, f_level}, 64'd3);
      chk("full_pop_head",  {32'd0, f_dataR}, 64'd2);
      drive(1'b1, 32'h5, 1'b0);
      settle();
      chk("refill_level", {{(64-LW){1'b0}}, f_level}, 64'd4);
      for (int k = 3; k <= 5; k++) begin
         drive(1'b0, '0, 1'b1);
         settle();
         chk("drain_order", {32'd0, f_dataR}, 64'(k));
      end
      drive(1'b0, '0, 1'b1);
      settle();
      chk("drain_empty", {63'd0, f_readyR}, 64'd0);

      // 4. streaming at full rate
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'(i), 1'b1);
         settle();
         chk("stream_level", {{(64-LW){1'b0}}, f_level}, 64'd1);
         chk("stream_data",  {32'd0, f_dataR}, 64'(i));
      end
      drive(1'b0, '0, 1'b1);
      settle();
      chk("stream_end_level", {{(64-LW){1'b0}}, f_level}, 64'd0);

      // 5. random stalls on both sides
      push_cnt = 0;
      cyc = 0;
      while (push_cnt < 1000 && cyc < 20000) begin
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
         cyc++;
      end
      chk("random_budget", {63'd0, push_cnt >= 1000}, 64'd1);
      repeat (DEPTH + 2) drive(1'b0, '0, 1'b1);
      settle();
      chk("random_drained", {{(64-LW){1'b0}}, f_level}, 64'd0);

      // 6. asynchronous reset at level 3
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hC0 + 32'(i), 1'b0);
         settle();
      end
      chk("pre_rst_level", {{(64-LW){1'b0}}, f_level}, 64'd3);
      #1 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_enableL", {63'd0, f_enableL}, 64'd1);
      chk("mid_rst_readyR",  {63'd0, f_readyR},  64'd0);
      chk("mid_rst_level",   {{(64-LW){1'b0}}, f_level}, 64'd0);
      chk("mid_rst_dataR",   {32'd0, f_dataR}, 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      f_readyL  = 1'b1;
      f_dataL   = 32'hA1;
      f_enableR = 1'b0;
      settle();
      drive(1'b1, 32'hA2, 1'b0);
      settle();
      chk("post_rst_level", {{(64-LW){1'b0}}, f_level}, 64'd2);
      chk("post_rst_first", {32'd0, f_dataR}, 64'hA1);
      drive(1'b0, '0, 1'b1);
      settle();
      chk("post_rst_second", {32'd0, f_dataR}, 64'hA2);
      drive(1'b0, '0, 1'b1);
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
